uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares the single UART transmit channel (`uart_send_ready` / `uart_send_req` / `uart_send_data`) between NREQ independent byte producers, for example the four quad core threads. It sits between the quad and the uart block in `fpga_func`:
- each requester gets a one-byte holding register with a valid/ready handshake;
- the arbiter issues one UART send pulse per byte and waits for the transmitter to go busy before granting again.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WAIT_CYC, 4: maximum cycles to wait for `uart_send_ready` to drop after a send pulse.
- CLK  in  1  single clock, rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i offers a byte.
- req_data  in  8*NREQ  byte of requester i at bits [8*i+7:8*i].
- req_ready  out  NREQ  holding register i is empty; byte accepted when valid&ready.
- uart_send_ready  in  1  UART transmitter idle.
- uart_send_req  out  1  one-cycle send strobe.
- uart_send_data  out  8  byte for the UART, stable from the req cycle until the next grant.
- grant_id  out  3  index of the last granted requester (debug).

## Operation
- Holding registers `hold_data[i]` and `hold_valid[i]`:
  - `req_ready[i] = ~hold_valid[i]`; this is a pure register output, with no path from the UART side.
  - On accept, `hold_valid[i]` is set at the next edge.
  - A register cleared by a grant cannot be refilled in the same cycle; the earliest refill is the cycle after the clear.
- Round-robin pointer `rr_ptr` (width clog2(NREQ)):
  - Search starts at `rr_ptr` and picks the first i with `hold_valid[i]`, wrapping modulo NREQ.
  - After granting g, `rr_ptr = (g+1) mod NREQ`. For NREQ not a power of two, wrap explicitly at NREQ-1 → 0.
- FSM states: IDLE, WAIT.
  - IDLE: if `uart_send_ready` and any `hold_valid`, then grant g:
    - `uart_send_data <= hold_data[g]`
    - `uart_send_req <= 1`
    - `hold_valid[g] <= 0`
    - `grant_id <= g`
    - load the wait counter with WAIT_CYC
    - go to WAIT.
  - WAIT: `uart_send_req <= 0`.
    - If `uart_send_ready == 0`, go to IDLE.
    - Else decrement the counter; at 0, go to IDLE (timeout). This tolerates a UART that finishes within the window.
    - IDLE then waits for `uart_send_ready == 1` before the next grant.
- No byte is dropped or duplicated. Order within one requester is preserved. Across requesters, order is round-robin.
- Reset values: `req_ready` = all ones, `uart_send_req` = 0, `uart_send_data` = 0, `grant_id` = 0, `rr_ptr` = 0, state = IDLE, all `hold_valid` = 0.

## Timing
- Accept at edge t → `hold_valid` high after t → `uart_send_req` high in cycle t+2 if IDLE and `uart_send_ready` is high. Minimum latency is 2 cycles.
- `uart_send_req` is exactly one cycle wide. Back-to-back req pulses are never adjacent; at least one WAIT cycle separates them.
- Simultaneous valid on all requesters: grants go in pointer order, one per UART byte time.
- `uart_send_ready` low in IDLE stalls all grants. Holding registers keep their data, and `req_ready` stays low for the full registers.
- RSTN asserted mid-operation: everything returns to reset values asynchronously. Bytes still held are discarded. An in-flight UART byte is the uart block's concern.

## Configuration
- `UART_TX_ARB_PRIO_EN` defined:
  - Requester 0 has strict priority. Whenever `hold_valid[0]` is set in IDLE, it is granted.
  - `rr_ptr` only arbitrates among requesters 1..NREQ-1, wrapping 1..NREQ-1, reset value 1.
  - Granting 0 does not move `rr_ptr`.
- Not defined: pure round-robin over all NREQ requesters, as described above.

## Structure
- Package `uart_tx_arb_pkg`:
  - state encoding constants (IDLE=0, WAIT=1);
  - the default NREQ and WAIT_CYC;
  - the byte width constant (8).
- Sub-module `rr_pick`: combinational round-robin find-first. Inputs are the request vector and the start pointer. Outputs are the hit flag and the index. The priority override under the macro is done in the parent.

## Test plan
- Single byte: reset, `uart_send_ready`=1, requester 2 sends 0xA5 at cycle 10 → `uart_send_req` pulse at cycle 12 with `uart_send_data`=0xA5, `grant_id`=2, `req_ready[2]` low only during cycle 11.
- Fairness: all four requesters hold bytes 0x10/0x11/0x12/0x13. UART model drops ready for 20 cycles after each req → send order 0x10, 0x11, 0x12, 0x13. A refill on requester 0 is sent after 0x13.
- Stall: `uart_send_ready`=0 for 100 cycles with all registers full → no req pulses, `req_ready`=0000. After ready rises, the first req is within 1 cycle.
- Timeout: UART model never lowers ready → pulses spaced WAIT_CYC+2 cycles, every byte sent exactly once.
- Reset mid-stream: assert RSTN during WAIT with 3 bytes held → outputs at reset values immediately, no req after release until new valid.
- With `UART_TX_ARB_PRIO_EN`: requesters 1 and 3 pending, then requester 0 sends 0xFF → 0xFF is sent at the next grant ahead of the pending 1/3 bytes, and the round-robin order of 1 and 3 is unchanged.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared constants for the UART transmit arbiter: FSM encoding, default
// parameters and the byte width.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package uart_tx_arb_pkg;

  localparam int BYTE_W       = 8;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_WAIT_CYC = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin find-first: returns the first set request at or
// after the start pointer, wrapping modulo N.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic          hit,
  output logic [PW-1:0] idx
);

  logic [2*N-1:0] rot;
  logic [PW:0]    sum;

  // Rotate the request vector so bit 0 is the start position, then take the
  // lowest set bit; descending scan lets the lowest offset win.
  always_comb begin
    rot = {req, req} >> start;
    sum = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        sum = {1'b0, start} + (PW+1)'(k);
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
        idx = sum[PW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
// Shares one UART transmit channel between NREQ byte producers. Each producer
// has a one-byte holding register; a round-robin arbiter issues one send
// strobe per byte and waits for the transmitter to go busy (or a timeout)
// before granting again.
// Optional macro UART_TX_ARB_PRIO_EN: requester 0 gets strict priority and
// the round-robin pointer only covers requesters 1..NREQ-1.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   uart_send_ready,
  output logic                   uart_send_req,
  output logic [BYTE_W-1:0]      uart_send_data,
  output logic [2:0]             grant_id
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WAIT_CYC + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
`ifdef UART_TX_ARB_PRIO_EN
  localparam logic [PW-1:0] PTR_FIRST = PW'(1);
`else
  localparam logic [PW-1:0] PTR_FIRST = '0;
`endif

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [NREQ-1:0]   hold_valid;
  logic [BYTE_W-1:0] hold_data [NREQ];
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     rr_ptr_nxt;
  logic [CW-1:0]     wait_cnt;
  logic [NREQ-1:0]   pick_req;
  logic              pick_hit;
  logic [PW-1:0]     pick_idx;
  logic              grant_any;
  logic              grant_fire;
  logic [PW-1:0]     grant_idx;

  // Ready is a pure register output: empty holding register means ready.
  assign req_ready = ~hold_valid;

`ifdef UART_TX_ARB_PRIO_EN
  // Requester 0 is handled by the override, so hide it from the rotation.
  assign pick_req = hold_valid & ~NREQ'(1);
`else
  assign pick_req = hold_valid;
`endif

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .req   (pick_req),
    .start (rr_ptr),
    .hit   (pick_hit),
    .idx   (pick_idx)
  );

  // Grant selection and the pointer value that follows it.
  always_comb begin
    grant_any = pick_hit;
    grant_idx = pick_idx;
`ifdef UART_TX_ARB_PRIO_EN
    if (hold_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
    grant_fire = (state == ST_IDLE) && uart_send_ready && grant_any;
    if (grant_idx == PTR_LAST) rr_ptr_nxt = PTR_FIRST;
    else                       rr_ptr_nxt = grant_idx + PW'(1);
`ifdef UART_TX_ARB_PRIO_EN
    if (grant_idx == '0) rr_ptr_nxt = rr_ptr;
`endif
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: leave WAIT once the UART goes busy or the window expires.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_fire) state_nxt = ST_WAIT;
      ST_WAIT: if (!uart_send_ready || wait_cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Holding registers, send strobe/data, debug id, wait counter and pointer.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hold_valid     <= '0;
      uart_send_req  <= 1'b0;
      uart_send_data <= '0;
      grant_id       <= '0;
      wait_cnt       <= '0;
      rr_ptr         <= PTR_FIRST;
      for (int i = 0; i < NREQ; i++) hold_data[i] <= '0;
    end else begin
      // Accept and clear never coincide: a grant needs hold_valid, accept needs ready.
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !hold_valid[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= req_data[BYTE_W*i +: BYTE_W];
        end else if (grant_fire && grant_idx == PW'(i)) begin
          hold_valid[i] <= 1'b0;
        end
      end
      uart_send_req <= grant_fire;
      if (grant_fire) begin
        uart_send_data <= hold_data[grant_idx];
        grant_id       <= 3'(grant_idx);
        wait_cnt       <= CW'(WAIT_CYC);
        rr_ptr         <= rr_ptr_nxt;
      end else if (state == ST_WAIT && uart_send_ready && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
// Directed self-checking bench for uart_tx_arb (NREQ=4, WAIT_CYC=4).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arb;

  localparam int NREQ = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_send_ready;
  logic        uart_send_req;
  logic [7:0]  uart_send_data;
  logic [2:0]  grant_id;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arb #(.NREQ(NREQ), .WAIT_CYC(4)) dut (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .uart_send_ready (uart_send_ready),
    .uart_send_req   (uart_send_req),
    .uart_send_data  (uart_send_data),
    .grant_id        (grant_id)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    req_valid = '0;
    req_data = '0;
    uart_send_ready = 1'b1;
    step();
    step();
    RSTN = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL reset_ready got %h want f", req_ready); end
    n_cmp++; if (uart_send_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", uart_send_req); end
    n_cmp++; if (uart_send_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", uart_send_data); end
    n_cmp++; if (grant_id !== 3'd0) begin n_err++; $display("FAIL reset_gid got %0d want 0", grant_id); end
  endtask

  task automatic test_single();
    do_reset();
    repeat (7) step();
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    step();
    req_valid = '0;
    n_cmp++; if (req_ready !== 4'b1011) begin n_err++; $display("FAIL single_ready_held got %b want 1011", req_ready); end
    n_cmp++; if (uart_send_req !== 1'b0) begin n_err++; $display("FAIL single_no_early_req got %b want 0", uart_send_req); end
    step();
    n_cmp++; if (uart_send_req !== 1'b1) begin n_err++; $display("FAIL single_req got %b want 1", uart_send_req); end
    n_cmp++; if (uart_send_data !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", uart_send_data); end
    n_cmp++; if (grant_id !== 3'd2) begin n_err++; $display("FAIL single_gid got %0d want 2", grant_id); end
    n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL single_ready_free got %b want 1111", req_ready); end
    step();
    n_cmp++; if (uart_send_req !== 1'b0 || uart_send_data !== 8'hA5) begin
      n_err++; $display("FAIL single_pulse_end req=%b data=%h want req=0 data=a5", uart_send_req, uart_send_data);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] got [$];
    logic [7:0] exp [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    int busy = 0;
    int adj = 0;
    logic prev = 1'b0;
    logic refilled = 1'b0;
    do_reset();
    req_data = 32'h13121110;
    req_valid = 4'hF;
    step();
    req_valid = '0;
    for (int c = 0; c < 200; c++) begin
      if (uart_send_req) begin
        got.push_back(uart_send_data);
        if (prev) adj++;
        busy = 20;
      end
      prev = uart_send_req;
      uart_send_ready = (busy == 0);
      if (busy > 0) busy--;
      if (!refilled && req_ready[0]) begin
        req_valid = 4'b0001;
        req_data[7:0] = 8'h20;
        refilled = 1'b1;
      end else begin
        req_valid = '0;
      end
      step();
    end
    uart_send_ready = 1'b1;
    n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL fair_count got %0d want 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        n_cmp++; if (got[i] !== exp[i]) begin n_err++; $display("FAIL fair_order[%0d] got %h want %h", i, got[i], exp[i]); end
      end
    end
    n_cmp++; if (adj !== 0) begin n_err++; $display("FAIL fair_adjacent got %0d want 0", adj); end
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset();
    uart_send_ready = 1'b0;
    req_data = 32'h33323130;
    req_valid = 4'hF;
    step();
    req_valid = '0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (uart_send_req) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL stall_pulses got %0d want 0", pulses); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready got %b want 0000", req_ready); end
    uart_send_ready = 1'b1;
    step();
    n_cmp++; if (uart_send_req !== 1'b1) begin n_err++; $display("FAIL stall_release_req got %b want 1", uart_send_req); end
    n_cmp++; if (uart_send_data !== 8'h30) begin n_err++; $display("FAIL stall_release_data got %h want 30", uart_send_data); end
  endtask

  task automatic test_timeout();
    logic [7:0] got [$];
    int when [$];
    do_reset();
    uart_send_ready = 1'b1;
    req_data = 32'h43424140;
    req_valid = 4'hF;
    step();
    req_valid = '0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (uart_send_req) begin
        got.push_back(uart_send_data);
        when.push_back(c);
      end
    end
    n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL tmo_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        n_cmp++; if (got[i] !== 8'(8'h40 + i)) begin n_err++; $display("FAIL tmo_data[%0d] got %h want %h", i, got[i], 8'(8'h40 + i)); end
      end
      if (i > 0 && i < when.size()) begin
        n_cmp++; if (when[i] - when[i-1] !== 6) begin n_err++; $display("FAIL tmo_spacing[%0d] got %0d want 6", i, when[i] - when[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    do_reset();
    uart_send_ready = 1'b1;
    req_data = 32'h53525150;
    req_valid = 4'hF;
    step();
    req_valid = '0;
    step();
    n_cmp++; if (uart_send_req !== 1'b1 || req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rmid_setup req=%b ready=%b want req=1 ready=0001", uart_send_req, req_ready);
    end
    #2;
    RSTN = 1'b0;
    #1;
    n_cmp++; if (uart_send_req !== 1'b0) begin n_err++; $display("FAIL rmid_req got %b want 0", uart_send_req); end
    n_cmp++; if (uart_send_data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h want 00", uart_send_data); end
    n_cmp++; if (grant_id !== 3'd0) begin n_err++; $display("FAIL rmid_gid got %0d want 0", grant_id); end
    n_cmp++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL rmid_ready got %b want 1111", req_ready); end
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (uart_send_req) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rmid_after_pulses got %0d want 0", pulses); end
  endtask

`ifdef UART_TX_ARB_PRIO_EN
  task automatic test_prio();
    logic [7:0] got [$];
    logic [7:0] exp [3] = '{8'hFF, 8'h11, 8'h33};
    int busy = 0;
    do_reset();
    uart_send_ready = 1'b0;
    req_data = 32'h33001100;
    req_valid = 4'b1010;
    step();
    req_valid = 4'b0001;
    req_data[7:0] = 8'hFF;
    step();
    req_valid = '0;
    for (int c = 0; c < 120; c++) begin
      if (uart_send_req) begin
        got.push_back(uart_send_data);
        busy = 20;
      end
      uart_send_ready = (busy == 0);
      if (busy > 0) busy--;
      step();
    end
    uart_send_ready = 1'b1;
    n_cmp++; if (got.size() !== 3) begin n_err++; $display("FAIL prio_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        n_cmp++; if (got[i] !== exp[i]) begin n_err++; $display("FAIL prio_order[%0d] got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_timeout();
    test_reset_mid();
`ifdef UART_TX_ARB_PRIO_EN
    test_prio();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
